safecrack_btn_conditioner: RTL and testbench

//   Front-end for the safecrack FSM. Synchronises raw active-low push-buttons and the password-change switch.

---
 rtl/safecrack_pkg.sv | 16 +
 rtl/safecrack_sync.sv | 34 +++
 rtl/safecrack_btn_conditioner.sv | 167 ++++++++++++++++
 tb/tb_safecrack_btn_conditioner.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/safecrack_pkg.sv
// Shared definitions for the safecrack front-end and FSM.
//   BTN_NONE      idle button code (no key pressed)
//   cond_state_t  press-conditioner FSM states
package safecrack_pkg;

   localparam logic [3:0] BTN_NONE = 4'b1111;

   typedef enum logic [2:0] {
      IDLE,
      QUALIFY,
      EMIT,
      HELD,
      REL_QUALIFY
   } cond_state_t;

endpackage

// File: rtl/safecrack_sync.sv
// Plain multi-flop synchroniser chain for asynchronous inputs.
//   clk    in   1      destination clock
//   rst_n  in   1      asynchronous reset, active-low (loads RST_VAL into every stage)
//   d      in   WIDTH  asynchronous input
//   q      out  WIDTH  synchronised output (last stage)
module safecrack_sync #(
   parameter int unsigned WIDTH   = 1,
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            chain[i] <= {WIDTH{RST_VAL}};
         end
      end else begin
         chain[0] <= d;
         for (int unsigned i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/safecrack_btn_conditioner.sv
// Button front-end for safecrack_fsm: synchronises and debounces the active-low
// push-buttons and the password-change switch, and turns each accepted single-key
// press into a one-cycle code.
//   clk          in   1      system clock
//   rst_n        in   1      asynchronous reset, active-low
//   key_n        in   N_BTN  raw buttons, active-low, asynchronous
//   ms_raw       in   1      raw password-change switch, asynchronous
//   btn_out      out  N_BTN  all-ones when idle; accepted code for exactly one cycle
//   btn_valid    out  1      high in the cycle btn_out carries a code
//   ms_out       out  1      synchronised, debounced switch level
//   multi_press  out  1      one-cycle pulse when a stable multi-key press is rejected
module safecrack_btn_conditioner
   import safecrack_pkg::*;
#(
   parameter int unsigned N_BTN           = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] key_n,
   input  logic             ms_raw,
   output logic [N_BTN-1:0] btn_out,
   output logic             btn_valid,
   output logic             ms_out,
   output logic             multi_press
);

   localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]   CNT_MAX  = CW'(DEBOUNCE_CYCLES);
   // Idle code widened from the FSM's 4-bit BTN_NONE to N_BTN bits.
   localparam logic [N_BTN-1:0] KEY_IDLE = {N_BTN{BTN_NONE[0]}};

   logic [N_BTN-1:0] key_s;
   logic             ms_s;

   safecrack_sync #(
      .WIDTH   (N_BTN),
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b1)
   ) u_key_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (key_n),
      .q     (key_s)
   );

   safecrack_sync #(
      .WIDTH   (1),
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b0)
   ) u_ms_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ms_raw),
      .q     (ms_s)
   );

   // ---------------- press FSM ----------------
   cond_state_t      state, state_nxt;
   logic [N_BTN-1:0] cand, cand_nxt;
   logic [CW-1:0]    cnt, cnt_nxt, cnt_inc;
   logic [N_BTN-1:0] pressed;
   logic             single;
   logic             mp_nxt;

   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

   // Exactly one key down <=> the active-high press mask is a nonzero power of two.
   assign pressed = ~cand;
   assign single  = (pressed != '0) && ((pressed & (pressed - N_BTN'(1))) == '0);

   always_comb begin
      state_nxt = state;
      cand_nxt  = cand;
      cnt_nxt   = cnt;
      mp_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (key_s != KEY_IDLE) begin
               cand_nxt  = key_s;
               cnt_nxt   = '0;
               state_nxt = QUALIFY;
            end
         end
         QUALIFY: begin
            if (key_s == KEY_IDLE) begin
               state_nxt = IDLE;
            end else if (key_s != cand) begin
               cand_nxt = key_s;
               cnt_nxt  = '0;
            end else if (cnt == CNT_LAST) begin
               if (single) begin
                  state_nxt = EMIT;
               end else begin
                  mp_nxt    = 1'b1;
                  state_nxt = HELD;
               end
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         EMIT: begin
            state_nxt = HELD;
         end
         HELD: begin
            if (key_s == KEY_IDLE) begin
               cnt_nxt   = '0;
               state_nxt = REL_QUALIFY;
            end
         end
         REL_QUALIFY: begin
            if (key_s != KEY_IDLE) begin
               state_nxt = HELD;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so the code appears in the
   // same cycle the FSM sits in EMIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cand        <= KEY_IDLE;
         cnt         <= '0;
         btn_out     <= KEY_IDLE;
         btn_valid   <= 1'b0;
         multi_press <= 1'b0;
      end else begin
         state       <= state_nxt;
         cand        <= cand_nxt;
         cnt         <= cnt_nxt;
         btn_out     <= (state_nxt == EMIT) ? cand : KEY_IDLE;
         btn_valid   <= (state_nxt == EMIT);
         multi_press <= mp_nxt;
      end
   end

   // ---------------- ms debouncer ----------------
   logic [CW-1:0] ms_cnt, ms_inc;

   assign ms_inc = (ms_cnt == CNT_MAX) ? ms_cnt : ms_cnt + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ms_cnt <= '0;
         ms_out <= 1'b0;
      end else if (ms_s == ms_out) begin
         ms_cnt <= '0;
      end else if (ms_cnt == CNT_LAST) begin
         ms_out <= ~ms_out;
         ms_cnt <= '0;
      end else begin
         ms_cnt <= ms_inc;
      end
   end

endmodule

// File: tb/tb_safecrack_btn_conditioner.sv
// Self-checking bench for safecrack_btn_conditioner (DEBOUNCE_CYCLES=8, SYNC_STAGES=2).
module tb_safecrack_btn_conditioner;

   localparam int unsigned DEB = 8;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] key_n = 4'hF;
   logic       ms_raw = 1'b0;
   logic [3:0] btn_out;
   logic       btn_valid, ms_out, multi_press;

   safecrack_btn_conditioner #(
      .N_BTN           (4),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_n       (key_n),
      .ms_raw      (ms_raw),
      .btn_out     (btn_out),
      .btn_valid   (btn_valid),
      .ms_out      (ms_out),
      .multi_press (multi_press)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Press acceptance is expressed as run lengths of the synchronised key value:
   // a non-idle value seen D+1 consecutive samples while armed is a press; the
   // conditioner re-arms after D+1 consecutive idle samples once release is watched.
   logic [3:0]  kq[$];
   logic        mq[$];
   logic        mwin[$];
   logic [3:0]  run_val;
   int unsigned run_len, rel_len, hold_skip;
   bit          armed;
   logic        m_ms;
   logic [3:0]  e_btn;
   logic        e_valid, e_mp;

   always @(posedge clk or negedge rst_n) begin : ref_model
      logic [3:0] s;
      logic       ms;
      bit         all_diff;
      if (!rst_n) begin
         kq = '{4'hF, 4'hF};
         mq = '{1'b0, 1'b0};
         mwin.delete();
         run_val = 4'hF; run_len = 0; rel_len = 0; hold_skip = 0;
         armed = 1'b1; m_ms = 1'b0;
         e_btn = 4'hF; e_valid = 1'b0; e_mp = 1'b0;
      end else begin
         s  = kq.pop_front(); kq.push_back(key_n);
         ms = mq.pop_front(); mq.push_back(ms_raw);
         e_btn = 4'hF; e_valid = 1'b0; e_mp = 1'b0;
         if (s == run_val) run_len++;
         else begin run_val = s; run_len = 1; end
         if (armed) begin
            if (s != 4'hF && run_len == DEB + 1) begin
               armed = 1'b0; rel_len = 0;
               if ($countones(~s) == 1) begin
                  e_btn = s; e_valid = 1'b1; hold_skip = 1;
               end else begin
                  e_mp = 1'b1; hold_skip = 0;
               end
            end
         end else if (hold_skip > 0) begin
            hold_skip--;
         end else if (s == 4'hF) begin
            rel_len++;
            if (rel_len == DEB + 1) armed = 1'b1;
         end else begin
            rel_len = 0;
         end
         // ms toggles when the last D samples all disagree with the output.
         mwin.push_back(ms);
         if (mwin.size() > DEB) void'(mwin.pop_front());
         if (mwin.size() == DEB) begin
            all_diff = 1'b1;
            foreach (mwin[i]) if (mwin[i] == m_ms) all_diff = 1'b0;
            if (all_diff) m_ms = ~m_ms;
         end
      end
   end

   // ---------------- checking helpers ----------------
   int unsigned n_checks = 0, n_errors = 0;
   int unsigned n_pulse = 0, n_multi = 0, n_ms_rise = 0;
   logic [3:0]  last_code = 4'hF;
   logic        ms_prev = 1'b0;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle: wait for the falling edge, compare against the model, track events.
   task automatic tick();
      @(negedge clk);
      n_checks++;
      if (btn_out !== e_btn || btn_valid !== e_valid || ms_out !== m_ms || multi_press !== e_mp) begin
         n_errors++;
         $display("FAIL model t=%0t btn_out=%b exp %b valid=%b exp %b ms_out=%b exp %b multi=%b exp %b",
                  $time, btn_out, e_btn, btn_valid, e_valid, ms_out, m_ms, multi_press, e_mp);
      end
      if (btn_valid === 1'b1) begin n_pulse++; last_code = btn_out; end
      if (multi_press === 1'b1) n_multi++;
      if (ms_out === 1'b1 && ms_prev === 1'b0) n_ms_rise++;
      ms_prev = ms_out;
   endtask

   task automatic hold(input logic [3:0] k, input int unsigned n);
      key_n = k;
      repeat (n) tick();
   endtask

   typedef struct {
      logic [3:0]  key;
      int unsigned cycles;
      int unsigned pulses;
      logic [3:0]  code;
      int unsigned multi;
   } vec_t;

   vec_t vec[9];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1);
   end

   initial begin : stim
      int unsigned p0, m0, r0, lat, r;
      bit          found;
      logic [3:0]  k;

      vec[0] = '{4'b1110, 40, 1, 4'b1110, 0};
      vec[1] = '{4'b1101, 20, 1, 4'b1101, 0};
      vec[2] = '{4'b1011, 12, 1, 4'b1011, 0};
      vec[3] = '{4'b0111,  9, 1, 4'b0111, 0};  // shortest accepted press
      vec[4] = '{4'b1110,  8, 0, 4'b1111, 0};  // one sample short
      vec[5] = '{4'b1100, 20, 0, 4'b1111, 1};
      vec[6] = '{4'b0000, 20, 0, 4'b1111, 1};
      vec[7] = '{4'b1111, 20, 0, 4'b1111, 0};
      vec[8] = '{4'b0110,  5, 0, 4'b1111, 0};

      // reset state
      tick(); tick();
      check("reset btn_out", btn_out, 4'hF);
      check("reset btn_valid", btn_valid, 0);
      check("reset ms_out", ms_out, 0);
      check("reset multi", multi_press, 0);
      rst_n = 1'b1;
      hold(4'hF, 5);

      // table vectors
      for (int i = 0; i < 9; i++) begin
         p0 = n_pulse; m0 = n_multi; last_code = 4'hF;
         hold(vec[i].key, vec[i].cycles);
         hold(4'hF, 30);
         check($sformatf("vec%0d pulses", i), n_pulse - p0, vec[i].pulses);
         check($sformatf("vec%0d multi", i), n_multi - m0, vec[i].multi);
         check($sformatf("vec%0d code", i), last_code, vec[i].code);
      end

      // press latency: 2 sync + 8 debounce + 1 emit
      p0 = n_pulse; found = 1'b0; lat = 0;
      key_n = 4'b1110;
      for (int c = 1; c <= 30 && !found; c++) begin
         tick();
         if (btn_valid === 1'b1) begin found = 1'b1; lat = c; end
      end
      check("press latency", found ? lat : 0, 11);
      check("press code", last_code, 4'b1110);
      hold(4'b1110, 29);
      hold(4'hF, 40);
      check("single pulse held", n_pulse - p0, 1);

      // bouncing press
      p0 = n_pulse;
      for (int b = 0; b < 7; b++) hold((b % 2) ? 4'hF : 4'b1101, 3);
      hold(4'b1101, 20);
      hold(4'hF, 30);
      check("bounce pulses", n_pulse - p0, 1);
      check("bounce code", last_code, 4'b1101);

      // multi press then a valid press
      p0 = n_pulse; m0 = n_multi;
      hold(4'b1100, 20); hold(4'hF, 30);
      hold(4'b1011, 20); hold(4'hF, 30);
      check("multi count", n_multi - m0, 1);
      check("after multi pulses", n_pulse - p0, 1);
      check("after multi code", last_code, 4'b1011);

      // release chatter, then a press before release has qualified
      p0 = n_pulse;
      hold(4'b0111, 20);
      for (int b = 0; b < 6; b++) hold((b % 2) ? 4'b0111 : 4'hF, 1);
      hold(4'hF, 4);
      hold(4'b1110, 20);
      hold(4'hF, 30);
      check("release chatter pulses", n_pulse - p0, 1);
      check("release chatter code", last_code, 4'b0111);

      // release qualification boundary: 9 idle samples re-arm, 8 do not
      p0 = n_pulse;
      hold(4'b0111, 20); hold(4'hF, 9); hold(4'b1110, 20); hold(4'hF, 30);
      check("rel 9 pulses", n_pulse - p0, 2);
      p0 = n_pulse;
      hold(4'b0111, 20); hold(4'hF, 8); hold(4'b1110, 20); hold(4'hF, 30);
      check("rel 8 pulses", n_pulse - p0, 1);

      // ms glitch then stable rise: 2 sync + 8 debounce
      r0 = n_ms_rise;
      ms_raw = 1'b1; repeat (3) tick();
      ms_raw = 1'b0; repeat (5) tick();
      check("ms glitch ignored", n_ms_rise - r0, 0);
      ms_raw = 1'b1; found = 1'b0; lat = 0;
      for (int c = 1; c <= 30 && !found; c++) begin
         tick();
         if (ms_out === 1'b1) begin found = 1'b1; lat = c; end
      end
      check("ms latency", found ? lat : 0, 10);
      repeat (20) tick();
      check("ms rises", n_ms_rise - r0, 1);
      ms_raw = 1'b0; repeat (15) tick();
      check("ms fall", ms_out, 0);

      // reset during QUALIFY
      key_n = 4'b1110;
      repeat (5) tick();
      #2; rst_n = 1'b0; #1;
      check("rst qualify btn_out", btn_out, 4'hF);
      check("rst qualify valid", btn_valid, 0);
      tick();
      rst_n = 1'b1;
      // reset during EMIT, key still held
      found = 1'b0;
      for (int c = 1; c <= 30 && !found; c++) begin
         tick();
         if (btn_valid === 1'b1) found = 1'b1;
      end
      check("emit after reset seen", found, 1);
      #2; rst_n = 1'b0; #1;
      check("rst emit btn_out", btn_out, 4'hF);
      check("rst emit valid", btn_valid, 0);
      tick();
      rst_n = 1'b1;
      p0 = n_pulse; last_code = 4'hF;
      hold(4'b1110, 30);
      hold(4'hF, 30);
      check("held key fresh pulse", n_pulse - p0, 1);
      check("held key code", last_code, 4'b1110);

      // randomized stimulus against the model
      for (int seg = 0; seg < 250; seg++) begin
         r = $urandom_range(0, 99);
         if (r < 45) k = 4'hF;
         else k = 4'($urandom_range(0, 14));
         if ($urandom_range(0, 3) == 0) ms_raw = ~ms_raw;
         if (r == 99) begin
            rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
         end
         hold(k, $urandom_range(1, 14));
      end
      hold(4'hF, 30);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
